ifetch: RTL

IFETCH -- requirements
Module: ifetch

---
 rtl/rv32_pkg.sv | 9 +
 rtl/ifetch_buf.sv | 62 ++++++
 rtl/ifetch.sv | 66 ++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 widths and constants for the fetch front end.
package rv32_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  // One buffer entry is {pc, instr}, pc in the upper half.
  localparam int ENTRY_W = XLEN + INSTR_W;
endpackage : rv32_pkg

// File: rtl/ifetch_buf.sv
// Small instruction FIFO holding {pc, instr} entries; head is read combinationally.
module ifetch_buf
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic [CNT_W-1:0]   count
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Pointer and occupancy next state; flush wins over any push/pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared on reset so the head reads zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push && !flush) mem_q[wptr_q] <= wdata;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule : ifetch_buf

// File: rtl/ifetch.sv
// Instruction fetch: PC register, imem addressing and push/pop/redirect control.
module ifetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic               push, pop;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;

  // A redirect suppresses both sides; a full buffer can still accept if it drains this cycle.
  assign o_valid = (count != '0);
  assign pop     = o_valid && i_ready && !i_redirect;
  assign push    = !i_redirect && ((count < DEPTH_C) || pop);

  // Fetch PC next state: redirect target (word aligned), sequential step, or hold.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (i_redirect) begin
      fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
    end
  end

  // Fetch PC register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fetch_pc_q <= RESET_PC;
    else          fetch_pc_q <= fetch_pc_d;
  end

  ifetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (i_redirect),
    .wdata   ({fetch_pc_q, i_imem_data}),
    .rdata   (head),
    .count   (count)
  );

  assign o_imem_addr = {2'b00, fetch_pc_q[31:2]};
  assign o_pc        = head[ENTRY_W-1:INSTR_W];
  assign o_instr     = head[INSTR_W-1:0];

endmodule : ifetch
